// File: rtl/sys_pkg.sv
// sys_pkg: command opcodes, operand register addresses and FSM state encoding for sys_cmd_ctrl
package sys_pkg;
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam int OP_A_ADDR = 0;
  localparam int OP_B_ADDR = 1;
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUNC, ALU_WAIT, TX_LO, TX_HI
  } state_e;
endpackage

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: UART command decoder driving register file, ALU and TX FIFO
module sys_cmd_ctrl
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    FIFO_FULL
);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d, tx_data_d;
  logic [3:0] fun_d;
  logic wr_en_d, rd_en_d, alu_en_d, gate_d, tx_vld_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic two_q, two_d;
  // Every output is the registered copy of its *_d value; strobes default low each cycle
  always_comb begin
    state_d = state_q;
    addr_d = RF_Address;
    wr_data_d = RF_WrData;
    fun_d = ALU_FUN;
    tx_data_d = TX_P_DATA;
    gate_d = CLK_GATE_EN;
    res_d = res_q;
    two_d = two_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    alu_en_d = 1'b0;
    tx_vld_d = 1'b0;
    case (state_q)
      IDLE: if (RX_D_VLD) begin
        if (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR)) state_d = WR_ADDR;
        else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD)) state_d = RD_ADDR;
        else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP)) state_d = OP_A;
        else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) begin
          state_d = ALU_FUNC;
          gate_d = 1'b1;
        end
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wr_data_d = RX_P_DATA;
        wr_en_d = 1'b1;
        state_d = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        rd_en_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (RF_RdData_VLD) begin
        res_d = {{DATA_WIDTH{1'b0}}, RF_RdData};
        two_d = 1'b0;
        state_d = TX_LO;
      end
      OP_A: if (RX_D_VLD) begin
        addr_d = ADDR_WIDTH'(OP_A_ADDR);
        wr_data_d = RX_P_DATA;
        wr_en_d = 1'b1;
        state_d = OP_B;
      end
      OP_B: if (RX_D_VLD) begin
        addr_d = ADDR_WIDTH'(OP_B_ADDR);
        wr_data_d = RX_P_DATA;
        wr_en_d = 1'b1;
        gate_d = 1'b1;
        state_d = ALU_FUNC;
      end
      ALU_FUNC: if (RX_D_VLD) begin
        fun_d = RX_P_DATA[3:0];
        alu_en_d = 1'b1;
        state_d = ALU_WAIT;
      end
      ALU_WAIT: if (ALU_OUT_VLD) begin
        res_d = ALU_OUT;
        two_d = 1'b1;
        gate_d = 1'b0;
        state_d = TX_LO;
      end
      TX_LO: if (!FIFO_FULL) begin
        tx_data_d = res_q[DATA_WIDTH-1:0];
        tx_vld_d = 1'b1;
        state_d = two_q ? TX_HI : IDLE;
      end
      TX_HI: if (!FIFO_FULL) begin
        tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        tx_vld_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      RF_Address <= '0;
      RF_WrData <= '0;
      RF_WrEn <= 1'b0;
      RF_RdEn <= 1'b0;
      ALU_EN <= 1'b0;
      ALU_FUN <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA <= '0;
      TX_D_VLD <= 1'b0;
      res_q <= '0;
      two_q <= 1'b0;
    end else begin
      state_q <= state_d;
      RF_Address <= addr_d;
      RF_WrData <= wr_data_d;
      RF_WrEn <= wr_en_d;
      RF_RdEn <= rd_en_d;
      ALU_EN <= alu_en_d;
      ALU_FUN <= fun_d;
      CLK_GATE_EN <= gate_d;
      TX_P_DATA <= tx_data_d;
      TX_D_VLD <= tx_vld_d;
      res_q <= res_d;
      two_q <= two_d;
    end
  end
endmodule

// File: doc/sys_cmd_ctrl.md
SYS_CMD_CTRL -- requirements
Module: sys_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: UART byte and register-file data width.
REQ-002 Parameter ADDR_WIDTH, default 4: register-file address width.
REQ-003 CLK  in  1  reference-domain clock (REF_CLK at SYS_TOP); one clock; all logic on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 RX_P_DATA  in  DATA_WIDTH  byte from synchronized UART RX.
REQ-006 RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid.
REQ-007 RF_Address  out  ADDR_WIDTH  register-file address.
REQ-008 RF_WrEn  out  1  register-file write strobe.
REQ-009 RF_RdEn  out  1  register-file read strobe.
REQ-010 RF_WrData  out  DATA_WIDTH  register-file write data.
REQ-011 RF_RdData  in  DATA_WIDTH  register-file read data.
REQ-012 RF_RdData_VLD  in  1  RF_RdData valid.
REQ-013 ALU_EN  out  1  ALU enable.
REQ-014 ALU_FUN  out  4  ALU function select.
REQ-015 ALU_OUT  in  2*DATA_WIDTH  ALU result.
REQ-016 ALU_OUT_VLD  in  1  ALU_OUT valid.
REQ-017 CLK_GATE_EN  out  1  ALU clock-gate enable.
REQ-018 TX_P_DATA  out  DATA_WIDTH  byte to TX async FIFO.
REQ-019 TX_D_VLD  out  1  one-cycle FIFO write strobe.
REQ-020 FIFO_FULL  in  1  TX FIFO full.

Function
REQ-021 Commands decoded from first byte in IDLE: 0xAA RF write (addr, data); 0xBB RF read (addr); 0xCC ALU with operands (A, B, FUN); 0xDD ALU no operands (FUN); other bytes ignored, stay IDLE.
REQ-022 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUNC, ALU_WAIT, TX_LO, TX_HI; each byte-consuming state advances only on RX_D_VLD.
REQ-023 0xAA: addr byte latched (low ADDR_WIDTH bits); on data byte, RF_WrEn=1 with RF_Address/RF_WrData for exactly one cycle, then IDLE; no TX response.
REQ-024 0xBB: on addr byte, RF_RdEn=1 one cycle, enter RD_WAIT; on RF_RdData_VLD, capture RF_RdData, go TX_LO, send one byte, then IDLE.
REQ-025 0xCC: byte A written to RF address 0x0, byte B to 0x1 (one-cycle RF_WrEn each), then ALU_FUNC; 0xDD goes straight to ALU_FUNC.
REQ-026 ALU_FUNC: on FUN byte, ALU_FUN=RX_P_DATA[3:0], ALU_EN=1 one cycle, enter ALU_WAIT; CLK_GATE_EN=1 from ALU_FUNC entry until ALU_OUT_VLD.
REQ-027 ALU_WAIT: on ALU_OUT_VLD capture ALU_OUT; TX_LO sends ALU_OUT[7:0], TX_HI sends ALU_OUT[15:8], then IDLE.
REQ-028 TX handshake: TX_D_VLD=1 for one cycle only when FIFO_FULL=0; while FIFO_FULL=1, hold state and TX_P_DATA, TX_D_VLD=0.
REQ-029 RX_D_VLD in RD_WAIT, ALU_WAIT, TX_LO, TX_HI is dropped; no queuing.
REQ-030 RF_WrEn, RF_RdEn, ALU_EN never asserted together; all outputs registered.

Reset
REQ-031 RST low: state IDLE; RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD = 0; RF_Address, RF_WrData, ALU_FUN, TX_P_DATA = 0; captured data cleared.
REQ-032 RST mid-command aborts it immediately; partial frames not completed after release.

Structure
REQ-033 Shared package sys_pkg holds command opcodes (0xAA/0xBB/0xCC/0xDD), operand addresses 0x0/0x1, and state enum.
REQ-034 Single module, no sub-modules; one FSM plus capture registers.

Verification
REQ-035 0xAA,0x05,0xA6 -> one-cycle RF_WrEn, RF_Address=0x5, RF_WrData=0xA6; no TX_D_VLD.
REQ-036 0xBB,0x05, RF_RdData=0xA6 -> one-cycle RF_RdEn at 0x5; TX_P_DATA=0xA6, one TX_D_VLD.
REQ-037 0xCC,0x0A,0x03,0x00, ALU_OUT=0x000D -> writes 0x0A@0x0, 0x03@0x1; ALU_FUN=0, ALU_EN pulse; TX bytes 0x0D then 0x00.
REQ-038 0xDD,0x02, ALU_OUT=0x001E with FIFO_FULL high 5 cycles -> TX_D_VLD withheld until FIFO_FULL low, then 0x1E, 0x00.
REQ-039 0x55 in IDLE then 0xAA,0x01,0x11 -> 0x55 ignored, write of 0x11@0x1 completes.
REQ-040 RST low after 0xCC,0x0A -> all outputs zero, IDLE; next 0xAA sequence behaves per REQ-035.
